// File: rtl/row_window_feeder_pkg.sv
// Shared definitions for the row convolution path.
//   clog2   : ceil(log2(value)), used to size counters and the last_count port
//   state_e : window feeder FSM encodings
package row_window_feeder_pkg;

  typedef enum logic [1:0] {
    ST_FILL  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_FLUSH = 2'd3
  } state_e;

  // Ceiling log2; values 0 and 1 both return 0
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned v;
    int unsigned r;
    v = (value > 0) ? value - 1 : 0;
    r = 0;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/row_window_shift.sv
// Left/center/right window register triple.
//   clk, rst  : clock, asynchronous active-high reset
//   shift_i   : L<=C, C<=R, R<=pix_i
//   flush_i   : L<=C, C<=R, R<=0 (right edge padding)
//   clear_i   : all three to 0 (row start)
//   pix_i     : incoming pixel
//   left_o / center_o / right_o : window registers
module row_window_shift
  import row_window_feeder_pkg::*;
#(
  parameter int unsigned BITWIDTH = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                shift_i,
  input  logic                flush_i,
  input  logic                clear_i,
  input  logic [BITWIDTH-1:0] pix_i,
  output logic [BITWIDTH-1:0] left_o,
  output logic [BITWIDTH-1:0] center_o,
  output logic [BITWIDTH-1:0] right_o
);

  logic [BITWIDTH-1:0] left_q, center_q, right_q;

  // Clear wins over flush wins over shift; the controller never asserts two at once
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      left_q   <= '0;
      center_q <= '0;
      right_q  <= '0;
    end else if (clear_i) begin
      left_q   <= '0;
      center_q <= '0;
      right_q  <= '0;
    end else if (flush_i) begin
      left_q   <= center_q;
      center_q <= right_q;
      right_q  <= '0;
    end else if (shift_i) begin
      left_q   <= center_q;
      center_q <= right_q;
      right_q  <= pix_i;
    end
  end

  assign left_o   = left_q;
  assign center_o = center_q;
  assign right_o  = right_q;

endmodule

// File: rtl/row_window_feeder.sv
// Builds zero-padded 3-pixel windows from a raster pixel stream and hands them
// to a row_filter one at a time.
//   clk, rst            : clock, asynchronous active-high reset
//   pix_valid/pix_in    : pixel input, accepted when pix_ready is high
//   pix_ready           : feeder in FILL and not in reset
//   data_in_valid       : one-cycle window issue strobe
//   din1/din2/din3      : left/center/right window pixels
//   last_count          : constant LAST_COUNT for the filter multiplier
//   data_out_valid      : filter done with the current window
//   win_col             : column of the window center
//   row_last            : current window is the last one of the row
module row_window_feeder
  import row_window_feeder_pkg::*;
#(
  parameter int unsigned BITWIDTH   = 8,
  parameter int unsigned ROW_WIDTH  = 32,
  parameter int unsigned LAST_COUNT = BITWIDTH
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              pix_valid,
  input  logic [BITWIDTH-1:0]               pix_in,
  output logic                              pix_ready,
  output logic                              data_in_valid,
  output logic [BITWIDTH-1:0]               din1,
  output logic [BITWIDTH-1:0]               din2,
  output logic [BITWIDTH-1:0]               din3,
  output logic [clog2(BITWIDTH)+2-1:0]      last_count,
  input  logic                              data_out_valid,
  output logic [clog2(ROW_WIDTH)-1:0]       win_col,
  output logic                              row_last
);

  localparam int unsigned LCW = clog2(BITWIDTH) + 2;
  localparam int unsigned CW  = clog2(ROW_WIDTH);
  localparam int unsigned ICW = clog2(ROW_WIDTH + 1);

  state_e         state_q;
  logic [ICW-1:0] in_cnt_q, in_cnt_d;
  logic [CW-1:0]  out_cnt_q, out_cnt_d;
  logic           div_q;
  logic           row_last_q;
  logic           shift_c, flush_c, clear_c;

  assign in_cnt_d  = in_cnt_q + ICW'(1);
  assign out_cnt_d = out_cnt_q + CW'(1);

  // Window register controls decoded from the current state
  assign shift_c = (state_q == ST_FILL) && pix_valid;
  assign flush_c = (state_q == ST_FLUSH);
  assign clear_c = (state_q == ST_WAIT) && data_out_valid && row_last_q;

  row_window_shift #(
    .BITWIDTH (BITWIDTH)
  ) u_shift (
    .clk      (clk),
    .rst      (rst),
    .shift_i  (shift_c),
    .flush_i  (flush_c),
    .clear_i  (clear_c),
    .pix_i    (pix_in),
    .left_o   (din1),
    .center_o (din2),
    .right_o  (din3)
  );

  // FSM and counters; data_in_valid/row_last are set on the edge entering ISSUE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_FILL;
      in_cnt_q   <= '0;
      out_cnt_q  <= '0;
      div_q      <= 1'b0;
      row_last_q <= 1'b0;
    end else begin
      div_q <= 1'b0;
      case (state_q)
        ST_FILL: begin
          if (pix_valid) begin
            in_cnt_q <= in_cnt_d;
            if (in_cnt_d >= ICW'(2)) begin
              state_q    <= ST_ISSUE;
              div_q      <= 1'b1;
              row_last_q <= (out_cnt_q == CW'(ROW_WIDTH - 1));
            end
          end
        end
        ST_ISSUE: state_q <= ST_WAIT;
        ST_WAIT: begin
          if (data_out_valid) begin
            row_last_q <= 1'b0;
            if (row_last_q) begin
              in_cnt_q  <= '0;
              out_cnt_q <= '0;
              state_q   <= ST_FILL;
            end else if (in_cnt_q == ICW'(ROW_WIDTH)) begin
              out_cnt_q <= out_cnt_d;
              state_q   <= ST_FLUSH;
            end else begin
              out_cnt_q <= out_cnt_d;
              state_q   <= ST_FILL;
            end
          end
        end
        ST_FLUSH: begin
          state_q    <= ST_ISSUE;
          div_q      <= 1'b1;
          row_last_q <= (out_cnt_q == CW'(ROW_WIDTH - 1));
        end
        default: state_q <= ST_FILL;
      endcase
    end
  end

  // Ready follows state but is held low for the whole reset assertion
  assign pix_ready     = (state_q == ST_FILL) && !rst;
  assign data_in_valid = div_q;
  assign win_col       = out_cnt_q;
  assign row_last      = row_last_q;
  assign last_count    = LCW'(LAST_COUNT);

endmodule

// File: tb/tb_row_window_feeder.sv
// Bench for row_window_feeder with ROW_WIDTH=4, BITWIDTH=8: a window-list model
// per row, a filter responder, and one negedge compare process.
module tb_row_window_feeder;

  localparam int W = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pix_valid = 1'b0;
  logic [7:0] pix_in = 8'h00;
  logic       pix_ready;
  logic       data_in_valid;
  logic [7:0] din1, din2, din3;
  logic [4:0] last_count;
  logic       data_out_valid;
  logic [1:0] win_col;
  logic       row_last;

  always #5 clk = ~clk;

  row_window_feeder #(
    .BITWIDTH  (8),
    .ROW_WIDTH (W)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .pix_valid      (pix_valid),
    .pix_in         (pix_in),
    .pix_ready      (pix_ready),
    .data_in_valid  (data_in_valid),
    .din1           (din1),
    .din2           (din2),
    .din3           (din3),
    .last_count     (last_count),
    .data_out_valid (data_out_valid),
    .win_col        (win_col),
    .row_last       (row_last)
  );

  typedef struct {
    logic [7:0] l;
    logic [7:0] c;
    logic [7:0] r;
    int         col;
    bit         last;
  } win_t;

  win_t exp_q[$];
  win_t seen[$];
  int   errors = 0;
  int   checks = 0;
  int   dly = 3;
  bit   inject = 0;
  bit   abort = 0;

  // monitor tracking
  bit   hold = 0;
  int   post = 0;
  bit   post_flush = 0;
  bit   exp_div_next = 0;
  bit   prev_div = 0;
  int   acc_row = 0;
  win_t held;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
    end
  endtask

  // Row model: window k is (p[k-1], p[k], p[k+1]) with zero outside the row
  function automatic void model_push(input logic [7:0] row[W]);
    for (int k = 0; k < W; k++) begin
      win_t w;
      w.l    = (k == 0)     ? 8'h00 : row[k-1];
      w.c    = row[k];
      w.r    = (k == W - 1) ? 8'h00 : row[k+1];
      w.col  = k;
      w.last = (k == W - 1);
      exp_q.push_back(w);
    end
  endfunction

  // Filter responder: data_out_valid high for one cycle, dly cycles after the issue
  initial begin
    int cnt;
    cnt = 0;
    data_out_valid = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        cnt = 0;
        data_out_valid = 1'b0;
      end else if (data_in_valid) begin
        cnt = dly;
        data_out_valid = inject;
      end else if (cnt > 0) begin
        cnt--;
        data_out_valid = (cnt == 0);
      end else begin
        data_out_valid = 1'b0;
      end
    end
  end

  // Compare process
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        hold = 0; post = 0; exp_div_next = 0; prev_div = 0; acc_row = 0;
      end else begin
        check("last_count", 32'(last_count), 32'd8);
        if (exp_div_next) begin
          check("issue_latency", 32'(data_in_valid), 32'd1);
          exp_div_next = 0;
        end
        if (post == 1) begin
          check("resume_ready", 32'(pix_ready), post_flush ? 32'd0 : 32'd1);
          post = post_flush ? 2 : 0;
        end else if (post == 2) begin
          check("flush_latency", 32'(data_in_valid), 32'd1);
          post = 0;
        end
        if (data_in_valid) begin
          win_t w;
          check("div_width", 32'(prev_div), 32'd0);
          check("issue_ready", 32'(pix_ready), 32'd0);
          if (exp_q.size() == 0) begin
            check("unexpected_window", 32'd1, 32'd0);
          end else begin
            w = exp_q.pop_front();
            check("din1", 32'(din1), 32'(w.l));
            check("din2", 32'(din2), 32'(w.c));
            check("din3", 32'(din3), 32'(w.r));
            check("win_col", 32'(win_col), 32'(w.col));
            check("row_last", 32'(row_last), 32'(w.last));
          end
          held.l = din1; held.c = din2; held.r = din3;
          held.col = int'(win_col); held.last = row_last;
          seen.push_back(held);
          hold = 1;
        end else if (hold) begin
          check("wait_ready", 32'(pix_ready), 32'd0);
          check("hold_din1", 32'(din1), 32'(held.l));
          check("hold_din2", 32'(din2), 32'(held.c));
          check("hold_din3", 32'(din3), 32'(held.r));
          check("hold_col", 32'(win_col), 32'(held.col));
          check("hold_last", 32'(row_last), 32'(held.last));
        end
        if (hold && data_out_valid && !data_in_valid) begin
          hold = 0;
          post = 1;
          post_flush = (held.col == W - 2);
          if (held.last) acc_row = 0;
        end
        if (pix_valid && pix_ready) begin
          acc_row++;
          if (acc_row >= 2) exp_div_next = 1;
        end
        prev_div = data_in_valid;
      end
    end
  end

  task automatic send_pix(input logic [7:0] v);
    int n;
    bit acc;
    n = 0;
    acc = 0;
    pix_valid = 1'b1;
    pix_in = v;
    while (!acc && n < 300 && !abort) begin
      @(negedge clk);
      acc = pix_ready;
      @(posedge clk);
      #1;
      n++;
    end
    pix_valid = 1'b0;
    if (!abort) check("send_pix_accept", 32'(acc), 32'd1);
  endtask

  task automatic send_row(input logic [7:0] row[W], input bit gap);
    model_push(row);
    for (int k = 0; k < W; k++) begin
      if (abort) break;
      if (gap) begin
        pix_valid = 1'b0;
        @(posedge clk);
        #1;
      end
      send_pix(row[k]);
    end
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || hold || post != 0) && n < 600) begin
      @(posedge clk);
      #1;
      n++;
    end
    check(name, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_win(input string name, input int idx, input logic [7:0] l,
                           input logic [7:0] c, input logic [7:0] r, input int col, input bit last);
    if (idx >= seen.size()) begin
      check({name, "_present"}, 32'(seen.size()), 32'(idx + 1));
    end else begin
      check({name, "_l"}, 32'(seen[idx].l), 32'(l));
      check({name, "_c"}, 32'(seen[idx].c), 32'(c));
      check({name, "_r"}, 32'(seen[idx].r), 32'(r));
      check({name, "_col"}, 32'(seen[idx].col), 32'(col));
      check({name, "_last"}, 32'(seen[idx].last), 32'(last));
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] r[W];
    int base;

    // reset state
    @(negedge clk);
    check("rst_pix_ready", 32'(pix_ready), 32'd0);
    check("rst_div", 32'(data_in_valid), 32'd0);
    check("rst_din", {8'h0, din1, din2, din3}, 32'd0);
    check("rst_win_col", 32'(win_col), 32'd0);
    check("rst_row_last", 32'(row_last), 32'd0);
    check("rst_last_count", 32'(last_count), 32'd8);
    @(posedge clk);
    #3 rst = 1'b0;
    @(negedge clk);
    check("post_rst_ready", 32'(pix_ready), 32'd1);
    @(posedge clk);
    #1;

    // single row
    base = seen.size();
    r = '{8'd10, 8'd20, 8'd30, 8'd40};
    send_row(r, 0);
    wait_idle("s1_idle");
    check_win("s1_w0", base, 8'd0, 8'd10, 8'd20, 0, 0);
    check_win("s1_w3", base + 3, 8'd30, 8'd40, 8'd0, 3, 1);

    // back-to-back rows
    base = seen.size();
    send_row(r, 0);
    r = '{8'd1, 8'd2, 8'd3, 8'd4};
    send_row(r, 0);
    wait_idle("s2_idle");
    check("s2_count", 32'(seen.size() - base), 32'd8);
    check_win("s2_w4", base + 4, 8'd0, 8'd1, 8'd2, 0, 0);

    // backpressure with a stray done pulse in each issue cycle
    dly = 20;
    inject = 1;
    r = '{8'd10, 8'd20, 8'd30, 8'd40};
    send_row(r, 0);
    wait_idle("s3_idle");
    dly = 3;
    inject = 0;

    // input gaps
    base = seen.size();
    send_row(r, 1);
    wait_idle("s4_idle");
    check_win("s4_w1", base + 1, 8'd10, 8'd20, 8'd30, 1, 0);

    // reset during the wait of the second window
    base = seen.size();
    r = '{8'd1, 8'd2, 8'd3, 8'd4};
    fork
      send_row(r, 0);
      begin
        int n;
        n = 0;
        while (seen.size() < base + 2 && n < 200) begin
          @(posedge clk);
          #1;
          n++;
        end
        check("s5_reach_wait", 32'(seen.size()), 32'(base + 2));
        @(posedge clk);
        #2;
        abort = 1;
        rst = 1'b1;
        #1;
        check("s5_rst_div", 32'(data_in_valid), 32'd0);
        check("s5_rst_din", {8'h0, din1, din2, din3}, 32'd0);
        check("s5_rst_ready", 32'(pix_ready), 32'd0);
        check("s5_rst_col", 32'(win_col), 32'd0);
      end
    join
    exp_q.delete();
    @(posedge clk);
    #3;
    rst = 1'b0;
    abort = 0;
    @(posedge clk);
    #1;
    base = seen.size();
    r = '{8'd5, 8'd6, 8'd7, 8'd8};
    send_row(r, 0);
    wait_idle("s5_idle");
    check_win("s5_w0", base, 8'd0, 8'd5, 8'd6, 0, 0);

    // signed passthrough
    base = seen.size();
    r = '{8'h80, 8'h7F, 8'hFF, 8'h01};
    send_row(r, 0);
    wait_idle("s6_idle");
    check_win("s6_w0", base, 8'h00, 8'h80, 8'h7F, 0, 0);
    check_win("s6_w3", base + 3, 8'hFF, 8'h01, 8'h00, 3, 1);

    // randomized rows
    for (int i = 0; i < 8; i++) begin
      for (int k = 0; k < W; k++) r[k] = 8'($urandom);
      dly = int'($urandom_range(1, 6));
      send_row(r, bit'($urandom_range(0, 1)));
      wait_idle("rand_idle");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
